// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU execute stage.
//                - Opcode encodings (OP_AND .. OP_SLTU).
//                - Bit positions of the status flags inside out_flags.
//                - Payload record carried through the result skid buffer.
//  Config      : ALU_FLAGS_EN adds the flags field to the payload record.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Default datapath geometry used by the payload record.
    localparam int ALU_DW    = 32;
    localparam int ALU_TAG_W = 5;

    // Opcode encodings
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    // Flag bit positions: out_flags = {ovf, neg, zero}
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_W    = 3;

    // Payload layout, most significant field first. The execute stage packs
    // its skid-buffer word in exactly this order.
    typedef struct packed {
        logic [ALU_DW-1:0]    result;
        logic [ALU_TAG_W-1:0] rd;
`ifdef ALU_FLAGS_EN
        logic [FLAG_W-1:0]    flags;
`endif
    } alu_payload_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_and32.sv
`default_nettype none
// ============================================================================
//  Module      : alu_and32
//  Description : Bitwise AND unit of the execute stage.
//  Ports       : a_i, b_i  operands (DW bits)
//                y_o       a_i & b_i
//  Revision    : 1.0  initial release
// ============================================================================
module alu_and32 #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    assign y_o = a_i & b_i;

endmodule : alu_and32
`default_nettype wire

// File: rtl/alu_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_skid_buffer
//  Description : Two-entry register slice with valid/ready handshake.
//                Main register M drives the downstream side; skid register S
//                catches one beat when downstream stalls. One cycle latency,
//                one beat per clock sustained, strict FIFO ordering.
//  Ports       : clk, rst         clock, synchronous active-high reset
//                up_valid_i       upstream beat valid
//                up_ready_o       buffer can take a beat (S empty, not in reset)
//                up_data_i        upstream payload (PW bits)
//                dn_valid_o       M holds a beat
//                dn_ready_i       downstream accepts M
//                dn_data_o        contents of M
//  Revision    : 1.0  initial release
// ============================================================================
module alu_skid_buffer #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid_i,
    output logic          up_ready_o,
    input  logic [PW-1:0] up_data_i,
    output logic          dn_valid_o,
    input  logic          dn_ready_i,
    output logic [PW-1:0] dn_data_o
);

    logic          m_valid_q, m_valid_d;
    logic [PW-1:0] m_data_q,  m_data_d;
    logic          s_valid_q, s_valid_d;
    logic [PW-1:0] s_data_q,  s_data_d;

    logic          w_accept;
    logic          w_drain;

    // Ready depends only on the skid slot, so it never combinationally
    // follows dn_ready_i; a stalled downstream costs one extra beat of slack.
    assign up_ready_o = !s_valid_q && !rst;
    assign w_accept   = up_valid_i && up_ready_o;
    assign w_drain    = m_valid_q && dn_ready_i;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (w_drain) begin
            if (s_valid_q) begin
                // S refills M; no accept is possible while S is occupied.
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (w_accept) begin
                // Pass-through: M reloads in the same cycle, no bubble.
                m_data_d  = up_data_i;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = up_data_i;
            end else begin
                // M is held by a stalled downstream: park the beat in S.
                s_valid_d = 1'b1;
                s_data_d  = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    assign dn_valid_o = m_valid_q;
    assign dn_data_o  = m_data_q;

endmodule : alu_skid_buffer
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Registered ALU execute stage. Decodes the opcode, computes
//                the result combinationally (bitwise unit + shared
//                adder/subtractor) and registers it through a 2-entry skid
//                buffer toward writeback.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                in_valid/in_ready upstream handshake
//                in_op             opcode (alu_pkg OP_*)
//                in_a, in_b        operands (DW bits)
//                in_rd             destination tag, passed through
//                out_valid/out_ready downstream handshake
//                out_result        result (DW bits)
//                out_rd            destination tag of the result
//                out_flags         {ovf,neg,zero}, only with ALU_FLAGS_EN
//  Config      : `define ALU_FLAGS_EN to add out_flags and flag storage.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
    parameter int DW    = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_result,
    output logic [TAG_W-1:0] out_rd
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);

    import alu_pkg::*;

`ifdef ALU_FLAGS_EN
    localparam int PW = DW + TAG_W + FLAG_W;
`else
    localparam int PW = DW + TAG_W;
`endif

    logic [DW-1:0] w_and;
    logic          w_sub_mode;
    logic [DW-1:0] w_b_eff;
    logic [DW:0]   w_sum;
    logic          w_ovf;
    logic [DW-1:0] w_result;
    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;

    alu_and32 #(
        .DW (DW)
    ) u_and32 (
        .a_i (in_a),
        .b_i (in_b),
        .y_o (w_and)
    );

    // Single adder shared by ADD, SUB, SLT and SLTU. Subtraction is
    // a + ~b + 1; the carry out of the extended sum is the "no borrow" bit.
    assign w_sub_mode = (in_op != OP_ADD);
    assign w_b_eff    = w_sub_mode ? ~in_b : in_b;
    assign w_sum      = {1'b0, in_a} + {1'b0, w_b_eff} + {{DW{1'b0}}, w_sub_mode};

    // Signed overflow: operands of equal sign producing a result of the
    // other sign.
    assign w_ovf = (in_a[DW-1] == w_b_eff[DW-1]) && (w_sum[DW-1] != in_a[DW-1]);

    always_comb begin
        w_result = '0;
        case (in_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = in_a | in_b;
            OP_XOR:  w_result = in_a ^ in_b;
            OP_NOR:  w_result = ~(in_a | in_b);
            OP_ADD,
            OP_SUB:  w_result = w_sum[DW-1:0];
            // a < b signed when the true sign of a-b is negative, i.e. the
            // difference sign corrected for overflow.
            OP_SLT:  w_result = {{(DW-1){1'b0}}, w_sum[DW-1] ^ w_ovf};
            // a < b unsigned exactly when the subtraction borrows.
            OP_SLTU: w_result = {{(DW-1){1'b0}}, ~w_sum[DW]};
            default: w_result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0] w_flags;

    always_comb begin
        w_flags            = '0;
        w_flags[FLAG_ZERO] = (w_result == '0);
        w_flags[FLAG_NEG]  = w_result[DW-1];
        w_flags[FLAG_OVF]  = ((in_op == OP_ADD) || (in_op == OP_SUB)) && w_ovf;
    end

    // Same field order as alu_payload_t.
    assign w_in_data = {w_result, in_rd, w_flags};
    assign {out_result, out_rd, out_flags} = w_out_data;
`else
    assign w_in_data = {w_result, in_rd};
    assign {out_result, out_rd} = w_out_data;
`endif

    alu_skid_buffer #(
        .PW (PW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .up_valid_i (in_valid),
        .up_ready_o (in_ready),
        .up_data_i  (w_in_data),
        .dn_valid_o (out_valid),
        .dn_ready_i (out_ready),
        .dn_data_o  (w_out_data)
    );

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Self-checking bench for alu_exec_stage. Directed operation
//                table, hand-written reset/backpressure sequences, and a
//                randomized phase checked against a queue-based reference.
//  Config      : honours ALU_FLAGS_EN (flags compared only when defined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
`ifdef ALU_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    alu_exec_stage #(
        .DW    (32),
        .TAG_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
`ifdef ALU_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [2:0]  flags;   // {ovf, neg, zero}
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_drained = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    endtask

    // Reference: the operation as plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
        exp_t   e;
        longint sa, sb_, sr;
        logic   ovf;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ovf = 1'b0;
        case (op)
            3'd0: e.result = a & b;
            3'd1: e.result = a | b;
            3'd2: e.result = a ^ b;
            3'd3: e.result = ~(a | b);
            3'd4: begin sr = sa + sb_; e.result = a + b; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            3'd5: begin sr = sa - sb_; e.result = a - b; ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            3'd6: e.result = (sa < sb_) ? 32'd1 : 32'd0;
            default: e.result = (a < b) ? 32'd1 : 32'd0;
        endcase
        e.rd    = rd;
        e.flags = {ovf, e.result[31], e.result == 32'd0};
        return e;
    endfunction

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic ordy);
        logic acc, drn;
        exp_t e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        out_ready = ordy;
        #1;
        chk("in_ready_vs_occupancy", {63'd0, in_ready}, {63'd0, sb.size() < 2});
        chk("out_valid_vs_occupancy", {63'd0, out_valid}, {63'd0, sb.size() > 0});
        acc = v && in_ready;
        drn = out_valid && ordy;
        if (drn) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("drain_result", {32'd0, out_result}, {32'd0, e.result});
                chk("drain_rd", {59'd0, out_rd}, {59'd0, e.rd});
`ifdef ALU_FLAGS_EN
                chk("drain_flags", {61'd0, out_flags}, {61'd0, e.flags});
`endif
                n_drained++;
            end
        end
        if (acc) sb.push_back(model(op, a, b, rd));
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int k = 0; k < 8 && sb.size() > 0; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        chk("flush_empty", 64'(sb.size()), 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        exp_t ea, eb;
        logic [31:0] ra, rb;
        int d0;

        tbl[0] = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd1,  32'h00F0_1200, 3'b000};
        tbl[1] = '{3'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd2,  32'hFFF0_FF34, 3'b010};
        tbl[2] = '{3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3,  32'hFF00_ED34, 3'b010};
        tbl[3] = '{3'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4,  32'h000F_00CB, 3'b000};
        tbl[4] = '{3'd4, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5,  32'h8000_0000, 3'b110};
        tbl[5] = '{3'd5, 32'h0000_0005, 32'h0000_0005, 5'd6,  32'h0000_0000, 3'b001};
        tbl[6] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  32'h0000_0001, 3'b000};
        tbl[7] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 32'h0000_0000, 3'b001};

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_out_result", {32'd0, out_result}, 64'd0);
        chk("reset_out_rd", {59'd0, out_rd}, 64'd0);
`ifdef ALU_FLAGS_EN
        chk("reset_out_flags", {61'd0, out_flags}, 64'd0);
`endif
        rst = 1'b0;

        // Operation table: each result one cycle after accept
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, 1'b1);
            chk("tbl_latency_valid", {63'd0, out_valid}, 64'd1);
            chk("tbl_result", {32'd0, out_result}, {32'd0, tbl[i].exp_res});
            chk("tbl_rd", {59'd0, out_rd}, {59'd0, tbl[i].rd});
`ifdef ALU_FLAGS_EN
            chk("tbl_flags", {61'd0, out_flags}, {61'd0, tbl[i].exp_flags});
`endif
            cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        end

        // Backpressure: A in M, B in S, then drain A then B
        ea = model(3'd4, 32'd100, 32'd23, 5'd10);
        eb = model(3'd2, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd11);
        cycle(1'b1, 3'd4, 32'd100, 32'd23, 5'd10, 1'b0);
        cycle(1'b1, 3'd2, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd11, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_A", {32'd0, out_result}, {32'd0, ea.result});
        cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0); // rejected beat
        chk("bp_still_A", {32'd0, out_result}, {32'd0, ea.result});
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        chk("bp_B_next", {32'd0, out_result}, {32'd0, eb.result});
        chk("bp_B_rd", {59'd0, out_rd}, {59'd0, eb.rd});
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Reset mid-stream with two beats buffered
        cycle(1'b1, 3'd1, 32'h1, 32'h2, 5'd1, 1'b0);
        cycle(1'b1, 3'd1, 32'h3, 32'h4, 5'd2, 1'b0);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_in_ready_now", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
        sb.delete();
        repeat (3) cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);

        // Streaming: 100 back-to-back beats
        d0 = n_drained;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 3'(i % 8), $urandom, $urandom, 5'(i), 1'b1);
        chk("stream_no_bubble", 64'(n_drained - d0), 64'd99);
        flush();

        // Random valid/ready toggling
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb,
                  5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_alu_exec_stage
`default_nettype wire
